// File: rtl/asansor_scheduler.sv
// Three-floor elevator call scheduler and car motion controller.
// Build option: define ASANSOR_SCAN_EN for SCAN direction policy (default is nearest-first).
module asansor_scheduler #(
    parameter int unsigned MOVE_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_call,
    output logic [1:0] o_floor,
    output logic [1:0] o_dir,
    output logic       o_door,
    output logic [2:0] o_pending,
    output logic [1:0] o_led
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    localparam logic [7:0] MOVE_LOAD = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    state_t     state_r, state_s;
    logic [7:0] timer_r, timer_s;
    logic [1:0] floor_r, floor_s;
    logic [2:0] pending_r, pending_s;
    logic       door_r;
    logic [2:0] set_s, clr_s;
    logic [1:0] next_floor_s;
    logic       up_ahead_s, down_ahead_s, go_up_s;
`ifdef ASANSOR_SCAN_EN
    logic       last_up_r, last_up_s;
`endif

    function automatic logic [2:0] onehot(input logic [1:0] f);
        case (f)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] f);
        case (f)
            2'd0:    above_mask = 3'b110;
            2'd1:    above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] f);
        case (f)
            2'd1:    below_mask = 3'b001;
            2'd2:    below_mask = 3'b011;
            default: below_mask = 3'b000;
        endcase
    endfunction

    // State, timer, floor and pending-set registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= 8'd0;
            floor_r   <= 2'd0;
            pending_r <= 3'b000;
            door_r    <= 1'b0;
`ifdef ASANSOR_SCAN_EN
            last_up_r <= 1'b1;
`endif
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            floor_r   <= floor_s;
            pending_r <= pending_s;
            door_r    <= (state_s == ST_DOOR);
`ifdef ASANSOR_SCAN_EN
            last_up_r <= last_up_s;
`endif
        end
    end

    // Next-state, timer and pending-set update.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        floor_s      = floor_r;
        clr_s        = 3'b000;
        next_floor_s = floor_r;
        up_ahead_s   = |(pending_r & above_mask(floor_r));
        down_ahead_s = |(pending_r & below_mask(floor_r));
`ifdef ASANSOR_SCAN_EN
        last_up_s    = last_up_r;
        go_up_s      = last_up_r ? up_ahead_s : !down_ahead_s;
`else
        // With three floors a tie only happens at floor 1, and the lower floor wins.
        go_up_s      = up_ahead_s && !down_ahead_s;
`endif
        // A call at the open-door floor only extends the door, it is never latched.
        if (state_r == ST_DOOR) begin
            set_s = i_call & ~onehot(floor_r);
        end else begin
            set_s = i_call;
        end
        case (state_r)
            ST_IDLE: begin
                if (|(pending_r & onehot(floor_r))) begin
                    state_s = ST_DOOR;
                    clr_s   = onehot(floor_r);
                    timer_s = DOOR_LOAD;
                end else if (|pending_r) begin
                    state_s = go_up_s ? ST_MOVE_UP : ST_MOVE_DOWN;
                    timer_s = MOVE_LOAD;
`ifdef ASANSOR_SCAN_EN
                    last_up_s = go_up_s;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (timer_r != 8'd0) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    if (state_r == ST_MOVE_UP) begin
                        next_floor_s = (floor_r != 2'd2) ? floor_r + 2'd1 : floor_r;
                    end else begin
                        next_floor_s = (floor_r != 2'd0) ? floor_r - 2'd1 : floor_r;
                    end
                    floor_s = next_floor_s;
                    if (|(pending_r & onehot(next_floor_s))) begin
                        state_s = ST_DOOR;
                        clr_s   = onehot(next_floor_s);
                        timer_s = DOOR_LOAD;
                    end else if ((state_r == ST_MOVE_UP) ?
                                 |(pending_r & above_mask(next_floor_s)) :
                                 |(pending_r & below_mask(next_floor_s))) begin
                        timer_s = MOVE_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                if (i_call[floor_r]) begin
                    timer_s = DOOR_LOAD;
                end else if (timer_r != 8'd0) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = 8'd0;
            end
        endcase
        pending_s = (pending_r | set_s) & ~clr_s;
    end

    // Output decode from registers.
    always_comb begin
        o_floor   = floor_r;
        o_led     = floor_r;
        o_door    = door_r;
        o_pending = pending_r;
        case (state_r)
            ST_MOVE_UP:   o_dir = 2'b01;
            ST_MOVE_DOWN: o_dir = 2'b10;
            default:      o_dir = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_asansor_scheduler.sv
// Directed bench for asansor_scheduler: expectations are queued with target cycles
// and compared on the falling edge when that cycle arrives.
module tb_asansor_scheduler;
    localparam logic [1:0] D_STOP = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DN   = 2'b10;

    typedef struct {
        int         cyc;
        string      tag;
        logic [9:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] call = 3'b000;
    logic [1:0] floor_o, dir_o, led_o;
    logic       door_o;
    logic [2:0] pending_o;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t e;
    logic [9:0] obs;

    asansor_scheduler dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_call    (call),
        .o_floor   (floor_o),
        .o_dir     (dir_o),
        .o_door    (door_o),
        .o_pending (pending_o),
        .o_led     (led_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            obs = {floor_o, dir_o, door_o, pending_o, led_o};
            if (e.cyc != cyc) begin
                fails++;
                $error("FAIL %s stale expectation: at cycle %0d, required cycle %0d", e.tag, cyc, e.cyc);
            end else begin
                assert (obs === e.val) passes++;
                else begin
                    fails++;
                    $error("FAIL %s cyc=%0d observed floor/dir/door/pend/led=%b expected=%b",
                           e.tag, cyc, obs, e.val);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int c, input string tag, input logic [1:0] f,
                          input logic [1:0] d, input logic door, input logic [2:0] p);
        exp_t x;
        x.cyc = c;
        x.tag = tag;
        x.val = {f, d, door, p, f};
        q.push_back(x);
    endtask

    initial begin
        int b;
        // Reset, then a call to floor 2 from floor 0.
        tick(2);
        exp_at(cyc, "reset", 2'd0, D_STOP, 1'b0, 3'b000);
        rst = 1'b0;
        tick(1);
        b = cyc;
        exp_at(b + 1,  "t1_latch",    2'd0, D_STOP, 1'b0, 3'b100);
        exp_at(b + 2,  "t1_move",     2'd0, D_UP,   1'b0, 3'b100);
        exp_at(b + 9,  "t1_still0",   2'd0, D_UP,   1'b0, 3'b100);
        exp_at(b + 10, "t1_floor1",   2'd1, D_UP,   1'b0, 3'b100);
        exp_at(b + 17, "t1_still1",   2'd1, D_UP,   1'b0, 3'b100);
        exp_at(b + 18, "t1_arrive2",  2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 21, "t1_doorlast", 2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 22, "t1_idle",     2'd2, D_STOP, 1'b0, 3'b000);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        tick(22);

        // Door at floor 2 extended by a call on its third cycle.
        b = cyc;
        exp_at(b + 1, "t4_latch",   2'd2, D_STOP, 1'b0, 3'b100);
        exp_at(b + 2, "t4_open",    2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 5, "t4_reload",  2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 8, "t4_extend",  2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 9, "t4_close",   2'd2, D_STOP, 1'b0, 3'b000);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        tick(3);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        tick(5);

        // Reset from floor 2, then reset in the middle of a 0->2 trip.
        b = cyc;
        exp_at(b + 1, "t5_rst_idle", 2'd0, D_STOP, 1'b0, 3'b000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        b = cyc;
        exp_at(b + 6,  "t5_moving",   2'd0, D_UP,   1'b0, 3'b100);
        exp_at(b + 7,  "t5_rst_move", 2'd0, D_STOP, 1'b0, 3'b000);
        exp_at(b + 11, "t5_no_move",  2'd0, D_STOP, 1'b0, 3'b000);
        exp_at(b + 20, "t5_stay0",    2'd0, D_STOP, 1'b0, 3'b000);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(14);

        // Call for floor 0 while departing it on a 0->1 trip.
        b = cyc;
        exp_at(b + 1,  "t6_latch",   2'd0, D_STOP, 1'b0, 3'b010);
        exp_at(b + 5,  "t6_back",    2'd0, D_UP,   1'b0, 3'b011);
        exp_at(b + 10, "t6_door1",   2'd1, D_STOP, 1'b1, 3'b001);
        exp_at(b + 14, "t6_idle1",   2'd1, D_STOP, 1'b0, 3'b001);
        exp_at(b + 15, "t6_down",    2'd1, D_DN,   1'b0, 3'b001);
        exp_at(b + 22, "t6_still1",  2'd1, D_DN,   1'b0, 3'b001);
        exp_at(b + 23, "t6_door0",   2'd0, D_STOP, 1'b1, 3'b000);
        exp_at(b + 27, "t6_idle0",   2'd0, D_STOP, 1'b0, 3'b000);
        call = 3'b010;
        tick(1);
        call = 3'b000;
        tick(3);
        call = 3'b001;
        tick(1);
        call = 3'b000;
        tick(23);

        // Move up to floor 1 so the last direction is up.
        b = cyc;
        exp_at(b + 2,  "pos_up",    2'd0, D_UP,   1'b0, 3'b010);
        exp_at(b + 10, "pos_door1", 2'd1, D_STOP, 1'b1, 3'b000);
        exp_at(b + 14, "pos_idle1", 2'd1, D_STOP, 1'b0, 3'b000);
        call = 3'b010;
        tick(1);
        call = 3'b000;
        tick(14);

        // Idle at floor 1, call for floor 1.
        b = cyc;
        exp_at(b + 1, "t2_latch", 2'd1, D_STOP, 1'b0, 3'b010);
        exp_at(b + 2, "t2_open",  2'd1, D_STOP, 1'b1, 3'b000);
        exp_at(b + 3, "t2_open2", 2'd1, D_STOP, 1'b1, 3'b000);
        exp_at(b + 5, "t2_open4", 2'd1, D_STOP, 1'b1, 3'b000);
        exp_at(b + 6, "t2_close", 2'd1, D_STOP, 1'b0, 3'b000);
        call = 3'b010;
        tick(1);
        call = 3'b000;
        tick(6);

        // Simultaneous calls for floors 0 and 2 from floor 1.
        b = cyc;
`ifdef ASANSOR_SCAN_EN
        exp_at(b + 2,  "t3_dir1",   2'd1, D_UP,   1'b0, 3'b101);
        exp_at(b + 10, "t3_first",  2'd2, D_STOP, 1'b1, 3'b001);
        exp_at(b + 14, "t3_idle",   2'd2, D_STOP, 1'b0, 3'b001);
        exp_at(b + 15, "t3_dir2",   2'd2, D_DN,   1'b0, 3'b001);
        exp_at(b + 23, "t3_pass1",  2'd1, D_DN,   1'b0, 3'b001);
        exp_at(b + 31, "t3_second", 2'd0, D_STOP, 1'b1, 3'b000);
        exp_at(b + 35, "t3_done",   2'd0, D_STOP, 1'b0, 3'b000);
`else
        exp_at(b + 2,  "t3_dir1",   2'd1, D_DN,   1'b0, 3'b101);
        exp_at(b + 10, "t3_first",  2'd0, D_STOP, 1'b1, 3'b100);
        exp_at(b + 14, "t3_idle",   2'd0, D_STOP, 1'b0, 3'b100);
        exp_at(b + 15, "t3_dir2",   2'd0, D_UP,   1'b0, 3'b100);
        exp_at(b + 23, "t3_pass1",  2'd1, D_UP,   1'b0, 3'b100);
        exp_at(b + 31, "t3_second", 2'd2, D_STOP, 1'b1, 3'b000);
        exp_at(b + 35, "t3_done",   2'd2, D_STOP, 1'b0, 3'b000);
`endif
        call = 3'b101;
        tick(1);
        call = 3'b000;
        tick(35);

        // Drain any expectation the scoreboard has not reached yet.
        for (int i = 0; i < 10 && q.size() > 0; i++) tick(1);
        checks++;
        assert (q.size() === 0) passes++;
        else begin
            fails++;
            $error("FAIL drain observed=%0d left expected=0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
